// File: rtl/sched_pkg.sv
// sched_pkg: shared FSM state type and default sizing for the slot scheduler
package sched_pkg;
    typedef enum logic [1:0] {IDLE, SCAN, GRANT} state_t;
    localparam int SCHED_N = 16;
    localparam int SCHED_MAXHOLD = 8;
endpackage

// File: rtl/hold_timer.sv
// hold_timer: per-grant hold counter, tc flags the last permitted grant cycle
module hold_timer import sched_pkg::*; #(
    parameter int MAXHOLD = SCHED_MAXHOLD
) (
    input  logic CLK,
    input  logic R,
    input  logic clear,
    input  logic inc,
    output logic tc
);
    localparam int CW = (MAXHOLD > 1) ? $clog2(MAXHOLD) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clear ? '0 : inc ? cnt_q + CW'(1) : cnt_q;
    always_ff @(posedge CLK or negedge R)
        if (!R) cnt_q <= '0;
        else    cnt_q <= cnt_d;
    assign tc = cnt_q == CW'(MAXHOLD - 1);
endmodule

// File: rtl/onehot_slot_scheduler.sv
// onehot_slot_scheduler: rotating one-hot token arbiter with bounded grant length
module onehot_slot_scheduler import sched_pkg::*; #(
    parameter int N       = SCHED_N,
    parameter int MAXHOLD = SCHED_MAXHOLD
) (
    input  logic         CLK,
    input  logic         R,
    input  logic         EN,
    input  logic [N-1:0] REQ,
    input  logic         DONE,
    output logic [N-1:0] GNT,
    output logic [N-1:0] SLOT,
    output logic [N-1:0] MASK,
    output logic         BUSY,
    output logic         TIMEOUT
);
    state_t state_q, state_d;
    logic [N-1:0] slot_q, slot_d, gnt_q, gnt_d, slot_rot;
    logic busy_q, busy_d, to_q, to_d;
    logic hit, rel, tc, clr, inc;
    assign slot_rot = {slot_q[N-2:0], slot_q[N-1]};
    assign hit = |(REQ & slot_q);
    assign rel = DONE || !(|(REQ & gnt_q));
    hold_timer #(.MAXHOLD(MAXHOLD)) u_hold (
        .CLK(CLK), .R(R), .clear(clr), .inc(inc), .tc(tc)
    );
    // release outranks the terminal count, so TIMEOUT only fires on a forced end
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        gnt_d   = gnt_q;
        busy_d  = busy_q;
        to_d    = 1'b0;
        clr     = 1'b0;
        inc     = 1'b0;
        unique case (state_q)
            IDLE: begin
                gnt_d  = '0;
                busy_d = 1'b0;
                if (EN) state_d = SCAN;
            end
            SCAN: begin
                if (!EN) state_d = IDLE;
                else if (hit) begin
                    gnt_d   = slot_q;
                    busy_d  = 1'b1;
                    clr     = 1'b1;
                    state_d = GRANT;
                end else slot_d = slot_rot;
            end
            GRANT: begin
                if (rel || tc) begin
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    slot_d  = slot_rot;
                    to_d    = !rel;
                    state_d = EN ? SCAN : IDLE;
                end else inc = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge CLK or negedge R)
        if (!R) begin
            state_q <= IDLE;
            slot_q  <= N'(1);
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            to_q    <= to_d;
        end
    assign GNT     = gnt_q;
    assign SLOT    = slot_q;
    assign MASK    = slot_q - N'(1);
    assign BUSY    = busy_q;
    assign TIMEOUT = to_q;
endmodule

// File: doc/onehot_slot_scheduler.md
ONEHOT_SLOT_SCHEDULER -- requirements
Module: onehot_slot_scheduler

Interface
REQ-001 SHALL have parameter N, default 16, number of requester slots and width of the one-hot token.
REQ-002 SHALL have parameter MAXHOLD, default 8, maximum number of cycles one grant may last.
REQ-003 SHALL have port CLK  in  1  the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port R  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port EN  in  1  scheduler enable.
REQ-006 SHALL have port REQ  in  N  per-slot request, level-sensitive.
REQ-007 SHALL have port DONE  in  1  current grantee releases the resource.
REQ-008 SHALL have port GNT  out  N  registered grant, one-hot or all-zero.
REQ-009 SHALL have port SLOT  out  N  registered one-hot token, marking the slot currently examined.
REQ-010 SHALL have port MASK  out  N  SLOT minus 1 as an N-bit unsigned value, marking all slots below the token.
REQ-011 SHALL have port BUSY  out  1  high while a grant is active.
REQ-012 SHALL have port TIMEOUT  out  1  one-cycle pulse when a grant is force-ended.

Function
REQ-013 SHALL implement FSM states IDLE, SCAN and GRANT.
REQ-014 IDLE: GNT=0 and SLOT holds; EN=1 moves the FSM to SCAN on the next edge.
REQ-015 SCAN with (REQ & SLOT)!=0: SHALL load GNT=SLOT, set BUSY=1, clear the hold counter and move to GRANT, all on the next edge (1-cycle grant latency).
REQ-016 SCAN with no match: SLOT SHALL rotate left by one per cycle; bit N-1 wraps to bit 0.
REQ-017 SCAN with EN=0: SHALL move to IDLE on the next edge; SLOT does not rotate on that edge.
REQ-018 GRANT: GNT and SLOT SHALL hold and the hold counter SHALL increment each cycle.
REQ-019 GRANT ends on DONE=1, or on the granted REQ bit dropping; on the next edge GNT=0, BUSY=0 and SLOT rotates left by one.
REQ-020 GRANT with counter = MAXHOLD-1 and no release: SHALL end as in REQ-019 and pulse TIMEOUT for exactly one cycle.
REQ-021 Release and timeout in the same cycle: release wins and TIMEOUT stays 0.
REQ-022 After a grant ends, the FSM goes to SCAN if EN=1, else to IDLE; EN=0 never truncates an active grant.
REQ-023 Back-to-back grants to the same slot SHALL be impossible while any other slot requests (fairness: rotation follows every grant).
REQ-024 MASK SHALL be combinational from SLOT: SLOT=16'h0001 gives MASK=0, and SLOT=16'h8000 gives MASK=16'h7FFF.
REQ-025 The hold counter SHALL be $clog2(MAXHOLD) bits wide and never wrap within a grant.
REQ-026 GNT SHALL never have more than one bit set, and never a bit outside SLOT.

Reset
REQ-027 R=0 SHALL immediately (asynchronously) force: state IDLE, SLOT=1, GNT=0, BUSY=0, TIMEOUT=0, counter=0; MASK consequently 0.
REQ-028 Reset asserted during GRANT SHALL drop GNT without emitting TIMEOUT.
REQ-029 The first rising edge after R returns high SHALL be evaluated as from IDLE.

Structure
REQ-030 The state enum type, default N and default MAXHOLD SHALL live in the shared package sched_pkg.
REQ-031 The hold counter with terminal-count flag SHALL be the sub-module hold_timer (inputs CLK, R, clear, inc; output tc).
REQ-032 All sequential logic SHALL use nonblocking assignments and a single always_ff per register group with async R in the sensitivity list.

Verification
REQ-033 Reset, then EN=1 and REQ=16'h0008 -> SLOT walks 1,2,4,8; GNT=16'h0008 one edge after SLOT=8; MASK=16'h0007 during the grant.
REQ-034 Grant to slot 3 held with no DONE, MAXHOLD=8 -> GNT high exactly 8 cycles, TIMEOUT pulses 1 cycle, then SLOT=16'h0010.
REQ-035 REQ=16'h8001 both held, DONE after 2 cycles each -> grants alternate 16'h0001, 16'h8000, 16'h0001; SLOT wraps from 16'h8000 to 16'h0001.
REQ-036 DONE asserted in the cycle where the counter = MAXHOLD-1 -> grant ends and TIMEOUT=0.
REQ-037 EN dropped mid-grant -> grant completes on DONE, then IDLE with SLOT frozen; R pulsed low mid-GRANT -> GNT=0 and SLOT=1 immediately, no TIMEOUT.
